// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, prefetch depth,
// FSM state encoding and the buffered entry layout.
package fetch_pkg;

    localparam int ADDR_W = 5;  // PC / instruction memory address width (32 words)
    localparam int INS_W  = 8;  // 3-bit opcode + 5-bit operand
    localparam int DEPTH  = 2;  // prefetch buffer entries

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // issue permitted
        FULL  = 2'd1,  // entries + in-flight == DEPTH
        HALT  = 2'd2   // halt_i held, no new issues
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INS_W-1:0]  ins;
    } fetch_entry_t;

    // PC advance; wraps silently at the top of the address space.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the CPU decode stage.
//
// Handshake: the head instruction (ins_o/ins_addr_o) transfers on every rising
// edge where ins_valid_o && ins_ready_i. While ins_valid_o is high and
// ins_ready_i is low the head is held stable. ins_valid_o never depends on
// ins_ready_i. Memory side: mem_data_i is valid exactly one cycle after a
// cycle with mem_en_o high.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [INS_W-1:0]  mem_data_i;
    logic [INS_W-1:0]  ins_o;
    logic [ADDR_W-1:0] ins_addr_o;
    logic              ins_valid_o;
    logic              ins_ready_i;
    logic              jmp_i;
    logic [ADDR_W-1:0] jmp_addr_i;
    logic              halt_i;

    // fetch unit side
    modport master (
        output mem_en_o, mem_addr_o, ins_o, ins_addr_o, ins_valid_o,
        input  mem_data_i, ins_ready_i, jmp_i, jmp_addr_i, halt_i
    );

    // memory / CPU / control side
    modport slave (
        input  mem_en_o, mem_addr_o, ins_o, ins_addr_o, ins_valid_o,
        output mem_data_i, ins_ready_i, jmp_i, jmp_addr_i, halt_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched {addr, ins} entries. Flush clears
// it in one edge; push and pop may happen together even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int ENTRIES = DEPTH,
    localparam int PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int CW      = $clog2(ENTRIES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    fetch_entry_t  mem [ENTRIES];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(ENTRIES));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // pointer and occupancy bookkeeping; flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // entry storage needs no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the 32-word instruction
// memory, buffers up to DEPTH responses and hands them to decode via
// valid/ready. Taken jumps flush the buffer and drop the in-flight response.
// Optional feature macro: FETCH_STATS_EN adds fetch_cnt_o (saturating count of
// completed handshakes, cleared only by reset).
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    fetch_unit_if.master bus,
    output logic [1:0]  state_o
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] fetch_cnt_o
`endif
);

    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_FULL  = FULL;
    localparam logic [1:0] ST_HALT  = HALT;
    localparam int         CW       = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CW-1:0]     count;
    logic              empty;
    fetch_entry_t      head;
    fetch_entry_t      push_data;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occ_free;

    // a response is dropped if a jump is sampled on the edge it would land
    assign pop       = bus.ins_valid_o && bus.ins_ready_i;
    assign push      = inflight && !bus.jmp_i;
    assign push_data = '{addr: bus.mem_addr_o - 1'b1, ins: bus.mem_data_i};

    // occupancy after this cycle's pop; a same-cycle pop frees a slot
    assign occ_free = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue    = !rst_i && !bus.halt_i && !bus.jmp_i && (occ_free < (CW+1)'(DEPTH));

    assign bus.mem_en_o    = issue;
    assign bus.mem_addr_o  = pc;
    assign bus.ins_valid_o = !empty;
    assign bus.ins_o       = empty ? '0 : head.ins;
    assign bus.ins_addr_o  = empty ? '0 : head.addr;
    assign state_o         = state;

    fetch_fifo #(.ENTRIES(DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.jmp_i),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    // next FSM state from post-edge occupancy (buffered + newly issued)
    always_comb begin
        state_next = ST_FETCH;
        if (bus.jmp_i) begin
            state_next = bus.halt_i ? ST_HALT : ST_FETCH;
        end else if (bus.halt_i) begin
            state_next = ST_HALT;
        end else if ((occ_free + (CW+1)'(issue)) == (CW+1)'(DEPTH)) begin
            state_next = ST_FULL;
        end
    end

    // PC, in-flight tracking and FSM register; a jump overrides PC advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc       <= '0;
            inflight <= 1'b0;
            state    <= ST_FETCH;
        end else begin
            inflight <= issue;
            state    <= state_next;
            if (bus.jmp_i)  pc <= bus.jmp_addr_i;
            else if (issue) pc <= pc_inc(pc);
        end
    end

`ifdef FETCH_STATS_EN
    // saturating handshake counter, untouched by jumps
    always_ff @(posedge clk_i) begin
        if (rst_i)                            fetch_cnt_o <= '0;
        else if (pop && fetch_cnt_o != 16'hFFFF) fetch_cnt_o <= fetch_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized traffic,
// checked each cycle against a queue-based reference of the fetch pipeline.
module tb_fetch_unit;
    import fetch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_i;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    fetch_unit_if bus ();
    logic [1:0] state_o;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt_o;
`endif

    fetch_unit dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .bus     (bus),
        .state_o (state_o)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt_o (fetch_cnt_o)
`endif
    );

    // ---------------- scoreboard / reference ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  imem [32];
    logic [12:0] exp_q [$];      // {addr, ins} expected in the prefetch buffer
    int          m_pc;
    bit          m_infl;
    int          m_infl_addr;
    int          m_cnt;
    bit          m_init = 1'b0;  // model state defined (after first reset edge)
    bit          m_in_rst = 1'b0;
    logic        resp_en = 1'b0;
    logic [4:0]  resp_addr = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock cycle: apply inputs, compare at the falling edge, advance model.
    task automatic step(input logic rdy, input logic jmp, input logic [4:0] ja,
                        input logic hlt, input logic rst);
        bit exp_valid;
        bit pop;
        bit exp_en;
        int occ;
        bus.ins_ready_i = rdy;
        bus.jmp_i       = jmp;
        bus.jmp_addr_i  = ja;
        bus.halt_i      = hlt;
        rst_i           = rst;
        bus.mem_data_i  = resp_en ? imem[resp_addr] : 8'($urandom);
        @(negedge clk);

        exp_valid = (exp_q.size() > 0);
        pop       = exp_valid && rdy;
        occ       = exp_q.size() + int'(m_infl) - int'(pop);
        exp_en    = !rst && !hlt && !jmp && (occ < 2);

        if (m_init) begin
            check_val("mem_en", 32'(bus.mem_en_o), 32'(exp_en));
            if (exp_en) check_val("mem_addr", 32'(bus.mem_addr_o), 32'(m_pc));
            check_val("ins_valid", 32'(bus.ins_valid_o), 32'(exp_valid));
            if (exp_valid) begin
                check_val("ins_addr", 32'(bus.ins_addr_o), 32'(exp_q[0][12:8]));
                check_val("ins", 32'(bus.ins_o), 32'(exp_q[0][7:0]));
            end
            if (m_in_rst) begin
                check_val("rst_ins", 32'(bus.ins_o), 32'h0);
                check_val("rst_ins_addr", 32'(bus.ins_addr_o), 32'h0);
                check_val("rst_mem_addr", 32'(bus.mem_addr_o), 32'h0);
                check_val("rst_state", 32'(state_o), 32'(FETCH));
            end
`ifdef FETCH_STATS_EN
            check_val("fetch_cnt", 32'(fetch_cnt_o), 32'(m_cnt));
`endif
        end

        resp_en   = bus.mem_en_o;
        resp_addr = bus.mem_addr_o;

        // model update for the coming rising edge
        if (rst) begin
            exp_q.delete();
            m_pc     = 0;
            m_infl   = 1'b0;
            m_cnt    = 0;
            m_init   = 1'b1;
            m_in_rst = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            if (pop) begin
                void'(exp_q.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            if (m_infl && !jmp) exp_q.push_back({5'(m_infl_addr), imem[m_infl_addr]});
            m_infl = exp_en;
            if (exp_en) begin
                m_infl_addr = m_pc;
                m_pc = (m_pc + 1) % 32;
            end
            if (jmp) begin
                exp_q.delete();
                m_pc = int'(ja);
            end
        end

        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic hlt_lvl;
        bus.ins_ready_i = 1'b0;
        bus.jmp_i       = 1'b0;
        bus.jmp_addr_i  = '0;
        bus.halt_i      = 1'b0;
        bus.mem_data_i  = '0;
        rst_i           = 1'b1;
        for (int i = 0; i < 32; i++) imem[i] = 8'($urandom);

        // reset, then cold start and steady stream
        repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // back-pressure: buffer fills, issues stop, head holds
        repeat (5) step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // jump to 20 with one buffered entry and one request in flight
        step(1'b0, 1'b1, 5'd20, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // address wrap 28..31,0,1
        step(1'b1, 1'b1, 5'd28, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // halt while streaming: drain, then idle until release
        repeat (6) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // jump during halt, resume at target once halt drops
        repeat (2) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // handshake counter: 10 handshakes, jump, then reset
        step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && m_cnt < 10; i++) begin
            step((m_cnt < 9) || (exp_q.size() > 0), 1'b0, 5'd0, 1'b0, 1'b0);
        end
        check_val("hs_count_reached", 32'(m_cnt), 32'd10);
        step(1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
`ifdef FETCH_STATS_EN
        check_val("cnt_after_jump", 32'(fetch_cnt_o), 32'd10);
`endif
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
`ifdef FETCH_STATS_EN
        check_val("cnt_after_reset", 32'(fetch_cnt_o), 32'd0);
`endif

        // randomized traffic
        hlt_lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 14) == 0) hlt_lvl = ~hlt_lvl;
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 5'($urandom_range(0, 31)),
                 hlt_lvl,
                 $urandom_range(0, 149) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
